bsh_pipe: RTL and testbench
===========================

BSH_PIPE -- requirements
Module: bsh_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width; legal values are powers of two from 4 to 128.
REQ-002 SHALL have parameter SH_W, default $clog2(WIDTH), meaning shift-amount width; it is derived from WIDTH and is never overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input operand is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: stage 0 can accept this cycle.
REQ-007 SHALL have port data_in, input, WIDTH bits: the operand.
REQ-008 SHALL have port dir, input, 1 bit: 0 = left, 1 = right.
REQ-009 SHALL have port mode, input, 2 bits: 00 rotate, 01 logical shift, 10 arithmetic shift, 11 rotate (reserved alias).
REQ-010 SHALL have port sh, input, SH_W bits: the shift amount, 0..WIDTH-1.
REQ-011 SHALL have port out_valid, output, 1 bit: data_out is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream sink accepts.
REQ-013 SHALL have port data_out, output, WIDTH bits: the shifted result.

Function
REQ-014 SHALL implement SH_W registered stages; stage k applies a shift of 2^k when sh[k]=1, otherwise it passes the data through.
REQ-015 SHALL carry dir, mode and the remaining sh bits with the data through every stage.
REQ-016 SHALL have a latency of exactly SH_W cycles from input handshake to out_valid when there is no back-pressure.
REQ-017 SHALL sustain a throughput of 1 result per cycle while out_ready=1.
REQ-018 SHALL implement rotate with no bit loss: left is ((x<<s)|(x>>(WIDTH-s))); right is the mirror; s=0 returns x unchanged, with no out-of-range shift term.
REQ-019 SHALL implement logical shift by zero-filling vacated bits in either direction.
REQ-020 SHALL implement arithmetic right shift by filling vacated bits with data_in[WIDTH-1].
REQ-021 SHALL implement arithmetic left shift identically to logical left shift.
REQ-022 SHALL use per-stage valid with bubble collapse: stage k loads when valid[k]=0 or stage k+1 loads this cycle; the last stage loads when out_valid=0 or out_ready=1.
REQ-023 SHALL drive in_ready as the stage-0 load condition; in_ready is combinational from downstream state, with no combinational path from in_valid.
REQ-024 SHALL hold data_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drop no item and duplicate no item under any in_valid/out_ready pattern.
REQ-026 SHALL, when inputs are accepted and an output is consumed in the same cycle, advance both with no bubble inserted.
REQ-027 SHALL keep sh=0 with any mode and dir as a pure pass-through at full latency.

Reset
REQ-028 SHALL clear all stage valid bits on rst_n=0, giving out_valid=0.
REQ-029 SHALL clear data_out to 0 on rst_n=0.
REQ-030 SHALL, while rst_n=0, drive in_ready=1, but SHALL accept no item until the first clock edge after release.
REQ-031 SHALL discard all in-flight items on reset mid-operation, with no partial result presented.
REQ-032 SHALL leave data and sideband payload registers unreset; only valid bits and data_out are reset.

Structure
REQ-033 SHALL place the mode encodings (ROT, LSH, ASH, RSVD) and the dir encodings (LEFT=0, RIGHT=1) in shared package bsh_pkg.
REQ-034 SHALL use one sub-module, bsh_stage (parameters WIDTH and AMT = 2^k), instantiated SH_W times via generate; each instance holds its own registers and load logic.

Verification
REQ-035 SHALL verify: WIDTH=32, data_in=0x8000_0001, dir=0, mode=00, sh=1 -> data_out=0x0000_0003, out_valid 5 cycles after acceptance.
REQ-036 SHALL verify: data_in=0x8000_00F0, dir=1, mode=10, sh=4 -> 0xF800_000F; with mode=01 -> 0x0800_000F.
REQ-037 SHALL verify: data_in=0x1234_5678, sh=0, all mode/dir combinations -> 0x1234_5678 in every case.
REQ-038 SHALL verify: 100 back-to-back random items with out_ready held at 1 -> one result per cycle, in order, matching the reference model.
REQ-039 SHALL verify: out_ready=0 for 8 cycles with in_valid=1 -> exactly 5 items buffered, in_ready=0, data_out stable; on release, all 5 items delivered in order with none lost.
REQ-040 SHALL verify: rst_n pulsed low with 3 items in flight -> out_valid=0 immediately, and none of the 3 items appears after release.

Source files
------------

// File: rtl/bsh_pkg.sv
// bsh_pkg: shared mode and direction encodings for the pipelined barrel shifter.
package bsh_pkg;
  typedef enum logic [1:0] {
    MODE_ROT  = 2'b00,
    MODE_LSH  = 2'b01,
    MODE_ASH  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;
endpackage

// File: rtl/bsh_stage.sv
// bsh_stage: one registered shifter stage applying a fixed shift of AMT when its sh bit is set.
module bsh_stage import bsh_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_ld,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_dir,
  input  logic [1:0]               i_mode,
  input  logic [$clog2(WIDTH)-1:0] i_sh,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_dir,
  output logic [1:0]               o_mode,
  output logic [$clog2(WIDTH)-1:0] o_sh
);
  localparam int K    = $clog2(AMT);
  localparam bit LAST = (AMT == WIDTH / 2);
  logic                     r_valid;
  logic [WIDTH-1:0]         r_data;
  logic                     r_dir;
  logic [1:0]               r_mode;
  logic [$clog2(WIDTH)-1:0] r_sh;
  logic [WIDTH-1:0]         w_rot, w_shf, w_res, w_msk;
  logic                     w_right, w_arith, w_take;
  always_comb begin
    w_right = (i_dir == DIR_RIGHT);
    w_arith = (i_mode == MODE_ASH) && i_data[WIDTH-1];
    w_msk   = ~({WIDTH{1'b1}} >> AMT);
    w_rot   = w_right ? (i_data >> AMT) | (i_data << (WIDTH - AMT))
                      : (i_data << AMT) | (i_data >> (WIDTH - AMT));
    w_shf   = w_right ? (i_data >> AMT) | (w_arith ? w_msk : '0) : i_data << AMT;
    w_res   = !i_sh[K] ? i_data
            : (i_mode == MODE_LSH || i_mode == MODE_ASH) ? w_shf : w_rot;
    w_take  = i_ld && i_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_valid <= 1'b0;
    else if (i_ld) r_valid <= i_valid;
  always_ff @(posedge clk)
    if (w_take) begin
      r_dir  <= i_dir;
      r_mode <= i_mode;
      r_sh   <= i_sh;
    end
  // Only the final stage's data is visible as data_out, so only it gets a reset.
  if (LAST) begin : g_rst
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_data <= '0;
      else if (w_take) r_data <= w_res;
  end else begin : g_nrst
    always_ff @(posedge clk)
      if (w_take) r_data <= w_res;
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_dir   = r_dir;
  assign o_mode  = r_mode;
  assign o_sh    = r_sh;
endmodule

// File: rtl/bsh_pipe.sv
// bsh_pipe: SH_W-stage pipelined barrel shifter (rotate / logical / arithmetic) with
// valid/ready flow control and bubble collapse.
module bsh_pipe import bsh_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [SH_W-1:0]  sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
);
  logic [SH_W:0]    w_vld, w_dir;
  logic [SH_W-1:0]  w_ld;
  logic [WIDTH-1:0] w_data [SH_W+1];
  logic [1:0]       w_mode [SH_W+1];
  logic [SH_W-1:0]  w_sh   [SH_W+1];
  logic             w_unused;
  assign w_vld[0]  = in_valid;
  assign w_data[0] = data_in;
  assign w_dir[0]  = dir;
  assign w_mode[0] = mode;
  assign w_sh[0]   = sh;
  for (genvar k = 0; k < SH_W; k++) begin : g_st
    // A stage may load when it is empty or its successor is taking its item.
    if (k == SH_W - 1) begin : g_last
      assign w_ld[k] = !w_vld[k+1] || out_ready;
    end else begin : g_mid
      assign w_ld[k] = !w_vld[k+1] || w_ld[k+1];
    end
    bsh_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ld    (w_ld[k]),
      .i_valid (w_vld[k]),
      .i_data  (w_data[k]),
      .i_dir   (w_dir[k]),
      .i_mode  (w_mode[k]),
      .i_sh    (w_sh[k]),
      .o_valid (w_vld[k+1]),
      .o_data  (w_data[k+1]),
      .o_dir   (w_dir[k+1]),
      .o_mode  (w_mode[k+1]),
      .o_sh    (w_sh[k+1])
    );
  end
  assign in_ready  = w_ld[0];
  assign out_valid = w_vld[SH_W];
  assign data_out  = w_data[SH_W];
  assign w_unused  = ^{w_dir[SH_W], w_mode[SH_W], w_sh[SH_W]};
endmodule

// File: tb/tb_bsh_pipe.sv
// tb_bsh_pipe: table vectors, random streams and stall/reset sequences against a behavioural model.
module tb_bsh_pipe;
  import bsh_pkg::*;
  typedef struct {
    logic [31:0] d;
    logic        dr;
    logic [1:0]  m;
    logic [4:0]  s;
    logic [31:0] e;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, dir = 1'b0, out_valid, out_ready = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  sh = '0;
  logic [31:0] data_in = '0, data_out;
  logic [31:0] sb[$];
  vec_t        tv[18];
  int          n_tests = 0, n_fail = 0, n_out = 0;
  logic        last_ov = 1'b0, prev_stall = 1'b0;
  logic [31:0] last_do = '0, prev_do = '0;
  bsh_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .dir(dir), .mode(mode), .sh(sh),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_fn(input logic [31:0] x, input logic d,
                                         input logic [1:0] m, input logic [4:0] s);
    if (s == 0) return x;
    if (m == 2'b01 || (m == 2'b10 && !d)) return d ? x >> s : x << s;
    if (m == 2'b10) return $signed(x) >>> s;
    return d ? (x >> s) | (x << (32 - s)) : (x << s) | (x >> (32 - s));
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  // Called at a falling edge; samples one time unit before the next rising edge.
  task automatic tick();
    #4;
    if (prev_stall) begin
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_data", data_out, prev_do);
    end
    if (rst_n && in_valid && in_ready) sb.push_back(ref_fn(data_in, dir, mode, sh));
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else chk("sb_data", data_out, sb.pop_front());
    end
    last_ov    = out_valid;
    last_do    = data_out;
    prev_stall = out_valid && !out_ready;
    prev_do    = data_out;
    @(negedge clk);
  endtask
  task automatic drive(input logic [31:0] d, input logic dr, input logic [1:0] m, input logic [4:0] s);
    data_in = d; dir = dr; mode = m; sh = s;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int base, lat;
    tv[0]  = '{32'h8000_0001, 1'b0, 2'b00, 5'd1,  32'h0000_0003};
    tv[1]  = '{32'h8000_00F0, 1'b1, 2'b10, 5'd4,  32'hF800_000F};
    tv[2]  = '{32'h8000_00F0, 1'b1, 2'b01, 5'd4,  32'h0800_000F};
    for (int i = 0; i < 8; i++) tv[3+i] = '{32'h1234_5678, i[0], i[2:1], 5'd0, 32'h1234_5678};
    tv[11] = '{32'h8000_0001, 1'b1, 2'b00, 5'd1,  32'hC000_0000};
    tv[12] = '{32'hFFFF_FFFF, 1'b0, 2'b01, 5'd31, 32'h8000_0000};
    tv[13] = '{32'h0000_000F, 1'b0, 2'b10, 5'd4,  32'h0000_00F0};
    tv[14] = '{32'h7000_0000, 1'b1, 2'b10, 5'd31, 32'h0000_0000};
    tv[15] = '{32'h1234_5678, 1'b0, 2'b11, 5'd8,  32'h3456_7812};
    tv[16] = '{32'h8000_0000, 1'b1, 2'b10, 5'd31, 32'hFFFF_FFFF};
    tv[17] = '{32'h1234_5678, 1'b1, 2'b00, 5'd16, 32'h5678_1234};
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tv[i]) begin
      drive(tv[i].d, tv[i].dr, tv[i].m, tv[i].s);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      do begin tick(); lat++; end while (!last_ov && lat < 20);
      chk($sformatf("vec%0d_latency", i), lat, 32'd5);
      chk($sformatf("vec%0d_data", i), last_do, tv[i].e);
    end
    base = n_out;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive($urandom, 1'($urandom), 2'($urandom), 5'($urandom));
      tick();
    end
    chk("b2b_accepted_in_100", 32'(n_out - base + sb.size()), 32'd100);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("b2b_delivered", 32'(n_out - base), 32'd100);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
    base = n_out;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive($urandom, 1'($urandom), 2'($urandom), 5'($urandom));
      tick();
    end
    chk("stall_buffered", 32'(sb.size()), 32'd5);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    lat = 0;
    while (sb.size() != 0 && lat < 20) begin tick(); lat++; end
    chk("stall_released", 32'(n_out - base), 32'd5);
    for (int i = 0; i < 300; i++) begin
      drive($urandom, 1'($urandom), 2'($urandom), 5'($urandom));
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("random_bp_drained", 32'(sb.size()), 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1'b0, 2'b00, 5'($urandom));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("inflight_out_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_data_out", data_out, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 20; i++) tick();
    chk("post_rst_no_output", 32'(n_out - base), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
